imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
- Registered, multi-lane immediate-generation stage between fetch and rename/dispatch.
- Each beat carries LANES instruction words. Every valid lane gets its full RV32I/RV64I immediate decoded, sign- or zero-extended to XLEN, plus a format tag and an illegal flag.
- Adds AUIPC (U-type), JAL (J-type) and shift-amount (zero-extended shamt) handling.
- Uses a valid/ready handshake with a skid buffer so in_ready is a registered signal.

Parameters:
- LANES, 2, instructions per beat (≥1).
- XLEN, 32, output immediate width; only 32 or 64 are legal, anything else is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  LANES*32  instruction words; lane i at [32i+31:32i].
- in_lane_vld  in  LANES  per-lane valid within the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  LANES*32  instruction pass-through.
- out_lane_vld  out  LANES  per-lane valid pass-through.
- out_imm  out  LANES*XLEN  decoded immediates.
- out_fmt  out  LANES*3  format tag per lane (fmt_e).
- out_illegal  out  LANES  unknown opcode on a valid lane.

Behaviour:
- Reset values (next edge after reset high): out_valid=0, in_ready=1; main and skid valid cleared; out_imm/out_fmt/out_illegal/out_instr/out_lane_vld all 0.
- Reset mid-operation discards any held beats; nothing is replayed.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: 1 cycle. A beat accepted at edge N appears at out_* after edge N.
- Full throughput of 1 beat/cycle when out_ready stays high.
- Storage: main register feeds out_*; the skid register holds one extra decoded beat. in_ready = ~skid_valid, driven directly from a flop.
- State EMPTY (main=0, skid=0):
  - input transfer → FULL.
- State FULL (main=1, skid=0):
  - input & output transfer → FULL with new beat.
  - input only → SKID (new beat to skid).
  - output only → EMPTY.
- State SKID (main=1, skid=1), in_ready=0:
  - output transfer → FULL, skid moves into main.
- Ordering is strictly FIFO. Output data holds stable while out_valid & ~out_ready.
- Decode happens before registering; both registers store decoded results. Per-lane decode is on opcode = instr[6:0]:
  - 0010011 with funct3 001/101 → FMT_SH; imm = zero-extended shamt. shamt = instr[24:20] for XLEN=32, instr[25:20] for XLEN=64. instr[30] (SRAI) is excluded.
  - 0010011 (other funct3), 0000011, 1100111 → FMT_I; imm = sext(instr[31:20]).
  - 0100011 → FMT_S; imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 → FMT_B; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 → FMT_U; imm = sext({instr[31:12], 12'b0}). Upper bits are copies of instr[31] when XLEN=64.
  - 1101111 → FMT_J; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 → FMT_R; imm = 0.
  - Anything else → FMT_NONE; imm = 0; illegal = lane valid.
- Invalid lanes (in_lane_vld[i]=0) force imm=0, fmt=FMT_NONE and illegal=0 for that lane; the instruction still passes through.
- in_valid with in_lane_vld=0 is a legal beat and is transferred normally.
- in_* are don't-care while in_ready=0.

Decomposition:
- Package imm_pkg holds:
  - fmt_e (3-bit): FMT_NONE=0, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH.
  - Opcode localparams OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG.
- One sub-module, imm_lane_dec: combinational, per lane, parameterised by XLEN. Instantiate it LANES times via generate.
- The top level owns the handshake, main/skid registers and state logic.

Test Plan:
- Single-beat decode (LANES=2, XLEN=32): lane0=0xFFF00093, lane1=0xFFDFF06F, out_ready=1 → next cycle:
  - lane0: imm 0xFFFFFFFF, FMT_I.
  - lane1: imm 0xFFFFFFFC, FMT_J.
  - illegal=00.
- U/S/shift decode:
  - 0x123450B7 → 0x12345000 (FMT_U).
  - 0x0020A423 → 0x00000008 (FMT_S).
  - 0x4050D093 → 0x00000005 (FMT_SH, not 0x405).
  - Repeat at XLEN=64: 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
- Backpressure: stream beats A, B, C, D with in_valid=1; hold out_ready=0 for cycles 2–4 →
  - A is held stable on the output and B lands in skid; in_ready=0 from the edge after B's capture.
  - After out_ready=1, output order is A, B, C, D with no loss or duplication.
- Illegal/lane masking:
  - lane0=0x0000007F (valid) → illegal[0]=1, imm 0, FMT_NONE.
  - lane1=0xFFF00093 with in_lane_vld[1]=0 → imm 0, illegal[1]=0.
- Reset mid-operation: in SKID state, assert reset for 1 cycle → next cycle out_valid=0 and in_ready=1; a new beat then emerges 1 cycle after acceptance.
- Throughput: 16 back-to-back beats with out_ready=1 → 16 consecutive out_valid cycles with in_ready never low.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage: format tags and base opcodes.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6,
        FMT_SH   = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Sign-extend a 32-bit immediate to the widest supported XLEN; callers slice.
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/imm_lane_dec.sv
// Combinational immediate decoder for a single instruction lane.
module imm_lane_dec
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic            vld,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [63:0] raw;
    fmt_e        fmt_raw;
    logic        bad;
    logic [5:0]  shamt;

    // RV32 shifts only have a 5-bit shamt; bit 25 belongs to funct7 there.
    assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    always_comb begin
        raw     = '0;
        fmt_raw = FMT_NONE;
        bad     = 1'b0;
        case (instr[6:0])
            OP_IMM: begin
                if (instr[13:12] == 2'b01) begin
                    fmt_raw = FMT_SH;
                    raw     = {58'd0, shamt};
                end else begin
                    fmt_raw = FMT_I;
                    raw     = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OP_LOAD, OP_JALR: begin
                fmt_raw = FMT_I;
                raw     = sext32({{20{instr[31]}}, instr[31:20]});
            end
            OP_STORE: begin
                fmt_raw = FMT_S;
                raw     = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            OP_BRANCH: begin
                fmt_raw = FMT_B;
                raw     = sext32({{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0});
            end
            OP_LUI, OP_AUIPC: begin
                fmt_raw = FMT_U;
                raw     = sext32({instr[31:12], 12'd0});
            end
            OP_JAL: begin
                fmt_raw = FMT_J;
                raw     = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0});
            end
            OP_REG: fmt_raw = FMT_R;
            default: bad = 1'b1;
        endcase
    end

    assign imm     = vld ? raw[XLEN-1:0] : '0;
    assign fmt     = vld ? fmt_raw : FMT_NONE;
    assign illegal = vld & bad;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered multi-lane immediate generator with a skid buffer so in_ready is a flop.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_instr,
    input  logic [LANES-1:0]      in_lane_vld,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   out_instr,
    output logic [LANES-1:0]      out_lane_vld,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES*3-1:0]    out_fmt,
    output logic [LANES-1:0]      out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [LANES-1:0][31:0]   instr;
        logic [LANES-1:0]         lane_vld;
        logic [LANES-1:0][XLEN-1:0] imm;
        fmt_e [LANES-1:0]         fmt;
        logic [LANES-1:0]         illegal;
    } beat_t;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

    beat_t  dec, main_q, skid_q;
    state_e state_q, state_d;
    logic   in_ready_q, out_valid_q;
    logic   in_xfer, out_xfer;
    logic   ld_main_in, ld_main_skid, ld_skid;

    assign dec.instr    = in_instr;
    assign dec.lane_vld = in_lane_vld;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        imm_lane_dec #(.XLEN(XLEN)) u_dec (
            .instr   (in_instr[i*32 +: 32]),
            .vld     (in_lane_vld[i]),
            .imm     (dec.imm[i]),
            .fmt     (dec.fmt[i]),
            .illegal (dec.illegal[i])
        );
    end

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: if (in_xfer) begin
                state_d    = FULL;
                ld_main_in = 1'b1;
            end
            FULL: begin
                if (in_xfer && out_xfer) begin
                    ld_main_in = 1'b1;
                end else if (in_xfer) begin
                    state_d = SKID;
                    ld_skid = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            SKID: if (out_xfer) begin
                state_d      = FULL;
                ld_main_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake outputs are registered copies of the next state, not decodes of state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
            if (ld_main_in)        main_q <= dec;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= dec;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = main_q.instr;
    assign out_lane_vld = main_q.lane_vld;
    assign out_imm      = main_q.imm;
    assign out_fmt      = main_q.fmt;
    assign out_illegal  = main_q.illegal;

endmodule
